divider_decomposable_seq: RTL and testbench
===========================================

DIVIDER_DECOMPOSABLE_SEQ -- requirements
Module: divider_decomposable_seq

Interface
REQ-001 SHALL have parameter EACH_PART_LEN, default 8, width of one lane slice in bits.
REQ-002 SHALL have parameter N_PARTS, default 4, number of slices; only 4 is supported, enforced by an elaboration-time assertion.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mode  input  PRECISION_CONFIG_L  lane configuration (32B/16B/8B), sampled at accept.
REQ-006 SHALL have port in_dividend  input  32  packed unsigned dividends, lane k at bits [k*W +: W].
REQ-007 SHALL have port in_divisor  input  32  packed unsigned divisors, same packing.
REQ-008 SHALL have port in_valid  input  1  request valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a request.
REQ-010 SHALL have port out_quot  output  32  packed quotients.
REQ-011 SHALL have port out_rem  output  32  packed remainders.
REQ-012 SHALL have port out_dbz  output  4  divide-by-zero flag per lane; bit k refers to lane k.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-015 SHALL use lane width W=32/16/8 with 1/2/4 lanes for PRECISION_CONFIG_32B/16B/8B; any other mode encoding SHALL be processed as 32B.
REQ-016 SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-017 SHALL assert in_ready only in IDLE; accept occurs when in_valid&&in_ready, moving IDLE->BUSY and registering mode, dividend and divisor.
REQ-018 SHALL use radix-2 restoring division, one quotient bit per lane per cycle, MSB first; lane carries and borrows SHALL NOT cross lane boundaries.
REQ-019 SHALL count iterations with a counter cleared at accept; after W iterations it SHALL move BUSY->DONE, so out_valid rises exactly W cycles after the accept edge.
REQ-020 SHALL hold out_quot, out_rem, out_dbz and out_valid stable in DONE until out_valid&&out_ready, then move DONE->IDLE; sustained throughput is one request per W+2 cycles.
REQ-021 SHALL ignore in_valid in BUSY and DONE; no request is queued.
REQ-022 SHALL, for a lane with divisor 0, produce quotient all-ones (W bits), remainder equal to that lane's dividend, and out_dbz bit set.
REQ-023 SHALL drive unused out_dbz bits to 0 (bits 3:1 in 32B, bits 3:2 in 16B).
REQ-024 SHALL drive out_quot, out_rem and out_dbz to 0 whenever out_valid is 0.
REQ-025 SHALL produce exact results for all unsigned operands: quotient = floor(a/b), remainder = a - quotient*b < b.

Reset
REQ-026 SHALL, on rst high at a clock edge, enter IDLE and clear the counter and all datapath registers; out_valid=0, in_ready=1, and all data outputs are 0 from the following cycle.
REQ-027 SHALL abort any in-flight BUSY or DONE operation on reset with no result emitted; rst has priority over a simultaneous accept.

Structure
REQ-028 SHALL take PRECISION_CONFIG_L and the PRECISION_CONFIG_* encodings from pe_pkg; the FSM state enum SHALL be declared in pe_pkg.
REQ-029 SHALL instantiate one combinational sub-module, divider_step_decomposable, that performs one 32-bit restoring step with mode-controlled lane breaks at the 8- and 16-bit boundaries.

Verification
REQ-030 SHALL cover: 32B, 0x00000064 / 0x00000007 -> quot 0x0000000E, rem 0x00000002, dbz 0000, out_valid 32 cycles after accept.
REQ-031 SHALL cover: 8B, dividend 0xFF641009 / divisor 0x10070300 -> quot 0x0F0E05FF, rem 0x0F020109, dbz 0001, latency 8.
REQ-032 SHALL cover: 16B, 0x1234FFFF / 0x00100001 -> quot 0x0123FFFF, rem 0x00040000, dbz 0000, latency 16.
REQ-033 SHALL cover: 32B 5/9 with out_ready held low for 5 cycles and in_valid high -> quot 0, rem 5 held stable, in_ready 0, no second accept until the result handshake.
REQ-034 SHALL cover: rst pulsed at iteration 10 of a 32B op -> next cycle out_valid 0, in_ready 1, outputs 0, and no stale result afterwards.
REQ-035 SHALL cover: back-to-back 8B requests with in_valid and out_ready held high -> accepts spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/pe_pkg.sv
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types and helpers for the lane-decomposable divider.
//                Provides the precision/lane configuration type and its
//                encodings, the sequencer FSM state enum, and small
//                helper functions for mode normalisation, lane width and
//                per-lane divide-by-zero detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_pkg;

    localparam int c_data_w = 32;
    localparam int c_lanes  = 4;

    // Lane configuration: one 32-bit lane, two 16-bit lanes or four 8-bit lanes
    typedef logic [1:0] PRECISION_CONFIG_L;

    localparam PRECISION_CONFIG_L PRECISION_CONFIG_32B = 2'd0;
    localparam PRECISION_CONFIG_L PRECISION_CONFIG_16B = 2'd1;
    localparam PRECISION_CONFIG_L PRECISION_CONFIG_8B  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Unknown encodings collapse onto the single 32-bit lane configuration
    function automatic PRECISION_CONFIG_L norm_mode(input PRECISION_CONFIG_L m);
        if (m == PRECISION_CONFIG_16B || m == PRECISION_CONFIG_8B) begin
            return m;
        end
        return PRECISION_CONFIG_32B;
    endfunction

    // Lane width in bits; also the number of iterations an operation takes
    function automatic logic [5:0] lane_width(input PRECISION_CONFIG_L m);
        case (m)
            PRECISION_CONFIG_16B: return 6'd16;
            PRECISION_CONFIG_8B:  return 6'd8;
            default:              return 6'd32;
        endcase
    endfunction

    // One flag per active lane; flags for lanes that do not exist stay 0
    function automatic logic [3:0] dbz_flags(input PRECISION_CONFIG_L m,
                                             input logic [31:0]   d);
        logic [3:0] f;
        f = 4'b0000;
        case (m)
            PRECISION_CONFIG_8B: begin
                for (int k = 0; k < 4; k++) begin
                    f[k] = (d[8*k +: 8] == 8'd0);
                end
            end
            PRECISION_CONFIG_16B: begin
                f[0] = (d[15:0]  == 16'd0);
                f[1] = (d[31:16] == 16'd0);
            end
            default: begin
                f[0] = (d == 32'd0);
            end
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/divider_decomposable_seq_if.sv
// ============================================================================
//  Module      : divider_decomposable_seq_if
//  Description : Request/response bundle of the lane-decomposable divider.
//                Request side : mode, in_dividend, in_divisor, in_valid,
//                               in_ready (valid/ready handshake).
//                Response side: out_quot, out_rem, out_dbz, out_valid,
//                               out_ready (valid/ready handshake).
//                master = requester/consumer, slave = divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface divider_decomposable_seq_if;
    import pe_pkg::*;

    PRECISION_CONFIG_L mode;
    logic [31:0]       in_dividend;
    logic [31:0]       in_divisor;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       out_quot;
    logic [31:0]       out_rem;
    logic [3:0]        out_dbz;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mode, in_dividend, in_divisor, in_valid, out_ready,
        input  in_ready, out_quot, out_rem, out_dbz, out_valid
    );

    modport slave (
        input  mode, in_dividend, in_divisor, in_valid, out_ready,
        output in_ready, out_quot, out_rem, out_dbz, out_valid
    );

endinterface

`default_nettype wire

// File: rtl/divider_step_decomposable.sv
// ============================================================================
//  Module      : divider_step_decomposable
//  Description : One radix-2 restoring division step over a 32-bit word
//                that is split into 1, 2 or 4 independent lanes.
//                The word is built from four byte segments; the borrow
//                chain and the shift chain are broken at the 8/16/24-bit
//                boundaries according to the lane configuration.
//  Ports       : i_mode - normalised lane configuration
//                i_rem  - partial remainders (packed per lane)
//                i_quo  - dividend/quotient shift register (packed per lane)
//                i_div  - divisors (packed per lane)
//                o_rem  - partial remainders after this step
//                o_quo  - shift register after this step (new bit at lane LSB)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_step_decomposable
    import pe_pkg::*;
(
    input  PRECISION_CONFIG_L i_mode,
    input  logic [31:0]       i_rem,
    input  logic [31:0]       i_quo,
    input  logic [31:0]       i_div,
    output logic [31:0]       o_rem,
    output logic [31:0]       o_quo
);

    logic [3:0] w_start;        // segment k holds the LSB byte of a lane
    logic [1:0] w_top [4];      // index of the MSB segment of segment k's lane
    logic [7:0] w_shift [4];    // shifted partial remainder, per segment
    logic [8:0] w_diff [4];     // trial subtraction incl. borrow-out in bit 8
    logic [3:0] w_bout;
    logic [3:0] w_fit;          // lane's trial subtraction is non-negative
    logic       w_bchain;
    logic [31:0] w_rem_lo;      // i_rem shifted up by one (bit from segment below)
    logic [31:0] w_quo_lo;      // i_quo shifted up by one (bit from segment below)
    logic       w_in_bit;
    logic       w_q_bit;

    always_comb begin
        w_start  = 4'b0000;
        w_bout   = 4'b0000;
        w_fit    = 4'b0000;
        w_bchain = 1'b0;
        w_in_bit = 1'b0;
        w_q_bit  = 1'b0;
        o_rem    = '0;
        o_quo    = '0;
        w_rem_lo = {i_rem[30:0], 1'b0};
        w_quo_lo = {i_quo[30:0], 1'b0};
        for (int k = 0; k < 4; k++) begin
            w_top[k]   = 2'd0;
            w_shift[k] = 8'd0;
            w_diff[k]  = 9'd0;
        end

        // Lane topology
        for (int k = 0; k < 4; k++) begin
            case (i_mode)
                PRECISION_CONFIG_8B: begin
                    w_start[k] = 1'b1;
                    w_top[k]   = 2'(k);
                end
                PRECISION_CONFIG_16B: begin
                    w_start[k] = ((k % 2) == 0);
                    w_top[k]   = 2'(k | 1);
                end
                default: begin
                    w_start[k] = (k == 0);
                    w_top[k]   = 2'd3;
                end
            endcase
        end

        // Shift the remainder left; a lane's LSB receives the next dividend
        // bit (the lane's MSB of i_quo), otherwise the bit below carries up.
        // The borrow chain restarts at every lane start.
        for (int k = 0; k < 4; k++) begin
            w_in_bit   = w_start[k] ? i_quo[{w_top[k], 3'b111}] : w_rem_lo[8*k];
            w_shift[k] = {i_rem[8*k +: 7], w_in_bit};
            if (w_start[k]) begin
                w_bchain = 1'b0;
            end
            w_diff[k] = {1'b0, w_shift[k]} - {1'b0, i_div[8*k +: 8]} - {8'd0, w_bchain};
            w_bout[k] = w_diff[k][8];
            w_bchain  = w_diff[k][8];
        end

        // The bit shifted out of the lane MSB is the (W+1)th bit of the
        // shifted remainder: when set, the subtraction always succeeds.
        for (int k = 0; k < 4; k++) begin
            w_fit[k]       = i_rem[{w_top[k], 3'b111}] | ~w_bout[w_top[k]];
            o_rem[8*k +: 8] = w_fit[k] ? w_diff[k][7:0] : w_shift[k];
            w_q_bit        = w_start[k] ? w_fit[k] : w_quo_lo[8*k];
            o_quo[8*k +: 8] = {i_quo[8*k +: 7], w_q_bit};
        end
    end

endmodule

`default_nettype wire

// File: rtl/divider_decomposable_seq.sv
// ============================================================================
//  Module      : divider_decomposable_seq
//  Description : Sequential unsigned divider with 1x32, 2x16 or 4x8 lanes.
//                Accepts one request in IDLE, iterates one restoring step
//                per cycle for W cycles in BUSY, then holds the result in
//                DONE until the consumer takes it.
//  Ports       : clk - clock (rising edge)
//                rst - synchronous active-high reset
//                bus - request/response bundle (slave side)
//  Parameters  : EACH_PART_LEN - lane slice width (8)
//                N_PARTS       - number of slices (must be 4)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_decomposable_seq
    import pe_pkg::*;
#(
    parameter int EACH_PART_LEN = 8,
    parameter int N_PARTS       = 4
)(
    input  logic                       clk,
    input  logic                       rst,
    divider_decomposable_seq_if.slave  bus
);

    generate
        if (N_PARTS != c_lanes || EACH_PART_LEN * N_PARTS != c_data_w) begin : g_bad_cfg
            $error("divider_decomposable_seq: only 4 parts of 8 bits are supported");
        end
    endgenerate

    state_t            r_state;
    state_t            w_next;
    PRECISION_CONFIG_L r_mode;
    logic [31:0]       r_rem;
    logic [31:0]       r_quo;
    logic [31:0]       r_div;
    logic [3:0]        r_dbz;
    logic [5:0]        r_cnt;
    logic [5:0]        w_last;
    logic              w_accept;
    logic              w_valid;
    logic [31:0]       w_step_rem;
    logic [31:0]       w_step_quo;
    PRECISION_CONFIG_L w_in_mode;

    assign w_in_mode = norm_mode(bus.mode);
    assign w_last    = lane_width(r_mode) - 6'd1;
    assign w_accept  = (r_state == IDLE) && bus.in_valid;

    divider_step_decomposable u_step (
        .i_mode (r_mode),
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_div  (r_div),
        .o_rem  (w_step_rem),
        .o_quo  (w_step_quo)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)     w_next = BUSY;
            BUSY:    if (r_cnt == w_last)  w_next = DONE;
            DONE:    if (bus.out_ready)    w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= PRECISION_CONFIG_32B;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_dbz   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mode <= w_in_mode;
                r_rem  <= '0;
                r_quo  <= bus.in_dividend;
                r_div  <= bus.in_divisor;
                r_dbz  <= dbz_flags(w_in_mode, bus.in_divisor);
                r_cnt  <= '0;
            end else if (r_state == BUSY) begin
                // A zero divisor needs no special path: every step "fits",
                // giving an all-ones quotient and the dividend as remainder.
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
                r_cnt <= r_cnt + 6'd1;
            end
        end
    end

    assign w_valid       = (r_state == DONE);
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = w_valid;
    assign bus.out_quot  = w_valid ? r_quo : '0;
    assign bus.out_rem   = w_valid ? r_rem : '0;
    assign bus.out_dbz   = w_valid ? r_dbz : '0;

endmodule

`default_nettype wire

// File: tb/tb_divider_decomposable_seq.sv
// ============================================================================
//  Module      : tb_divider_decomposable_seq
//  Description : Self-checking bench for divider_decomposable_seq with a
//                per-lane arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_decomposable_seq;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    divider_decomposable_seq_if dif();

    divider_decomposable_seq #(
        .EACH_PART_LEN (8),
        .N_PARTS       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d)", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every lane is an independent unsigned division
    function automatic void model(input PRECISION_CONFIG_L m, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output logic [3:0] z);
        int w;
        logic [63:0] la, lb, qq, rr, mask;
        w = (m == PRECISION_CONFIG_8B) ? 8 : (m == PRECISION_CONFIG_16B) ? 16 : 32;
        mask = (64'd1 << w) - 64'd1;
        q = '0; r = '0; z = '0;
        for (int k = 0; k < 32 / w; k++) begin
            la = ({32'd0, a} >> (k * w)) & mask;
            lb = ({32'd0, b} >> (k * w)) & mask;
            if (lb == 64'd0) begin
                qq = mask; rr = la; z[k] = 1'b1;
            end else begin
                qq = la / lb; rr = la % lb;
            end
            q = q | 32'(qq << (k * w));
            r = r | 32'(rr << (k * w));
        end
    endfunction

    function automatic int lane_w(input PRECISION_CONFIG_L m);
        return (m == PRECISION_CONFIG_8B) ? 8 : (m == PRECISION_CONFIG_16B) ? 16 : 32;
    endfunction

    function automatic logic [31:0] rand_divisor();
        logic [31:0] d;
        d = $urandom;
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
                0: d[8*k +: 8] = 8'd0;
                1: d[8*k +: 8] = 8'($urandom_range(1, 3));
                default: ;
            endcase
        end
        if ($urandom_range(0, 7) == 0) d = 32'd0;
        return d;
    endfunction

    // Runs one transaction with the consumer ready right after out_valid
    task automatic run_op(input PRECISION_CONFIG_L m, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] q,
                          output logic [31:0] r, output logic [3:0] z, output int lat);
        int guard;
        dif.mode = m; dif.in_dividend = a; dif.in_divisor = b;
        dif.in_valid = 1'b1; dif.out_ready = 1'b0;
        guard = 0;
        while (dif.in_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
        tick();
        dif.in_valid = 1'b0;
        lat = 0;
        while (dif.out_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
        q = dif.out_quot; r = dif.out_rem; z = dif.out_dbz;
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; dif.in_valid = 1'b0; dif.out_ready = 1'b0;
        dif.mode = PRECISION_CONFIG_32B; dif.in_dividend = '0; dif.in_divisor = '0;
        tick(); tick();
        n_checks++; if (dif.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b want=1", dif.in_ready); end
        n_checks++; if (dif.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b want=0", dif.out_valid); end
        n_checks++; if ({dif.out_quot, dif.out_rem, dif.out_dbz} !== 68'd0) begin
            n_errors++; $display("FAIL reset_outputs got q=%h r=%h z=%b want all 0", dif.out_quot, dif.out_rem, dif.out_dbz); end
        rst = 1'b0;
        tick();
        n_checks++; if (dif.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_idle got in_ready=%b want=1", dif.in_ready); end
    endtask

    task automatic test_directed();
        PRECISION_CONFIG_L dm [3] = '{PRECISION_CONFIG_32B, PRECISION_CONFIG_8B, PRECISION_CONFIG_16B};
        logic [31:0] da [3] = '{32'h0000_0064, 32'hFF64_1009, 32'h1234_FFFF};
        logic [31:0] db [3] = '{32'h0000_0007, 32'h1007_0300, 32'h0010_0001};
        logic [31:0] eq [3] = '{32'h0000_000E, 32'h0F0E_05FF, 32'h0123_FFFF};
        logic [31:0] er [3] = '{32'h0000_0002, 32'h0F02_0109, 32'h0004_0000};
        logic [3:0]  ez [3] = '{4'b0000, 4'b0001, 4'b0000};
        int          el [3] = '{32, 8, 16};
        logic [31:0] q, r;
        logic [3:0]  z;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(dm[i], da[i], db[i], q, r, z, lat);
            n_checks++; if (q !== eq[i]) begin n_errors++; $display("FAIL directed%0d_quot got=%h want=%h", i, q, eq[i]); end
            n_checks++; if (r !== er[i]) begin n_errors++; $display("FAIL directed%0d_rem got=%h want=%h", i, r, er[i]); end
            n_checks++; if (z !== ez[i]) begin n_errors++; $display("FAIL directed%0d_dbz got=%b want=%b", i, z, ez[i]); end
            n_checks++; if (lat !== el[i]) begin n_errors++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, el[i]); end
        end
    endtask

    task automatic test_random();
        PRECISION_CONFIG_L m;
        logic [31:0] a, b, q, r, eq, er;
        logic [3:0]  z, ez;
        int          lat;
        for (int i = 0; i < 30; i++) begin
            m = PRECISION_CONFIG_L'($urandom_range(0, 3));
            a = $urandom;
            b = rand_divisor();
            model(m, a, b, eq, er, ez);
            run_op(m, a, b, q, r, z, lat);
            n_checks++; if (q !== eq) begin n_errors++; $display("FAIL random%0d_quot mode=%0d a=%h b=%h got=%h want=%h", i, m, a, b, q, eq); end
            n_checks++; if (r !== er) begin n_errors++; $display("FAIL random%0d_rem mode=%0d a=%h b=%h got=%h want=%h", i, m, a, b, r, er); end
            n_checks++; if (z !== ez) begin n_errors++; $display("FAIL random%0d_dbz mode=%0d b=%h got=%b want=%b", i, m, b, z, ez); end
            n_checks++; if (lat !== lane_w(m)) begin n_errors++; $display("FAIL random%0d_latency mode=%0d got=%0d want=%0d", i, m, lat, lane_w(m)); end
        end
    endtask

    task automatic test_backpressure();
        int guard, lat;
        bit ready_in_busy;
        dif.mode = PRECISION_CONFIG_32B; dif.in_dividend = 32'd5; dif.in_divisor = 32'd9;
        dif.in_valid = 1'b1; dif.out_ready = 1'b0;
        guard = 0;
        while (dif.in_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
        tick();
        // Keep offering a different request; it must not be taken
        dif.in_dividend = 32'h0000_1234; dif.in_divisor = 32'd3;
        lat = 0; ready_in_busy = 1'b0;
        while (dif.out_valid !== 1'b1 && lat < 100) begin
            if (dif.in_ready !== 1'b0) ready_in_busy = 1'b1;
            tick(); lat++;
        end
        n_checks++; if (lat !== 32) begin n_errors++; $display("FAIL bp_latency got=%0d want=32", lat); end
        n_checks++; if (ready_in_busy !== 1'b0) begin n_errors++; $display("FAIL bp_ready_in_busy got=1 want=0"); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (dif.out_quot !== 32'd0) begin n_errors++; $display("FAIL bp_hold%0d_quot got=%h want=0", i, dif.out_quot); end
            n_checks++; if (dif.out_rem !== 32'd5) begin n_errors++; $display("FAIL bp_hold%0d_rem got=%h want=5", i, dif.out_rem); end
            n_checks++; if (dif.in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_hold%0d_in_ready got=%b want=0", i, dif.in_ready); end
            n_checks++; if (dif.out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold%0d_out_valid got=%b want=1", i, dif.out_valid); end
            tick();
        end
        dif.out_ready = 1'b1; dif.in_valid = 1'b0;
        tick();
        dif.out_ready = 1'b0;
        n_checks++; if ({dif.in_ready, dif.out_valid} !== 2'b10) begin
            n_errors++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", dif.in_ready, dif.out_valid); end
    endtask

    task automatic test_reset_abort();
        int guard;
        bit stale;
        dif.mode = PRECISION_CONFIG_32B; dif.in_dividend = $urandom; dif.in_divisor = 32'd7;
        dif.in_valid = 1'b1; dif.out_ready = 1'b1;
        guard = 0;
        while (dif.in_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
        tick();
        dif.in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (dif.out_valid !== 1'b0) begin n_errors++; $display("FAIL abort_out_valid got=%b want=0", dif.out_valid); end
        n_checks++; if (dif.in_ready !== 1'b1) begin n_errors++; $display("FAIL abort_in_ready got=%b want=1", dif.in_ready); end
        n_checks++; if ({dif.out_quot, dif.out_rem, dif.out_dbz} !== 68'd0) begin
            n_errors++; $display("FAIL abort_outputs got q=%h r=%h z=%b want all 0", dif.out_quot, dif.out_rem, dif.out_dbz); end
        stale = 1'b0;
        repeat (40) begin
            if (dif.out_valid !== 1'b0) stale = 1'b1;
            tick();
        end
        n_checks++; if (stale !== 1'b0) begin n_errors++; $display("FAIL abort_stale_result got=1 want=0"); end
        // Reset wins over an accept presented on the same edge
        dif.mode = PRECISION_CONFIG_8B; dif.in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; dif.in_valid = 1'b0;
        n_checks++; if (dif.in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_priority got in_ready=%b want=1", dif.in_ready); end
        dif.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          acc [$];
        logic [31:0] qq [$], rq [$];
        logic [3:0]  zq [$];
        logic [31:0] eq, er;
        logic [3:0]  ez;
        int          n_res;
        bit          accepted;
        n_res = 0;
        dif.mode = PRECISION_CONFIG_8B; dif.in_dividend = $urandom; dif.in_divisor = rand_divisor();
        dif.in_valid = 1'b1; dif.out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (dif.out_valid === 1'b1) begin
                n_res++;
                if (qq.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL b2b_unexpected_result at cycle %0d", cyc);
                end else begin
                    eq = qq.pop_front(); er = rq.pop_front(); ez = zq.pop_front();
                    n_checks++; if (dif.out_quot !== eq) begin n_errors++; $display("FAIL b2b_quot got=%h want=%h", dif.out_quot, eq); end
                    n_checks++; if (dif.out_rem !== er) begin n_errors++; $display("FAIL b2b_rem got=%h want=%h", dif.out_rem, er); end
                    n_checks++; if (dif.out_dbz !== ez) begin n_errors++; $display("FAIL b2b_dbz got=%b want=%b", dif.out_dbz, ez); end
                end
            end
            accepted = (dif.in_ready === 1'b1) && (dif.in_valid === 1'b1);
            if (accepted) begin
                acc.push_back(cyc);
                model(PRECISION_CONFIG_8B, dif.in_dividend, dif.in_divisor, eq, er, ez);
                qq.push_back(eq); rq.push_back(er); zq.push_back(ez);
            end
            tick();
            if (accepted) begin
                if (acc.size() == 4) dif.in_valid = 1'b0;
                else begin dif.in_dividend = $urandom; dif.in_divisor = rand_divisor(); end
            end
        end
        dif.in_valid = 1'b0; dif.out_ready = 1'b0;
        n_checks++; if (acc.size() !== 4) begin n_errors++; $display("FAIL b2b_accepts got=%0d want=4", acc.size()); end
        n_checks++; if (n_res !== 4) begin n_errors++; $display("FAIL b2b_results got=%0d want=4", n_res); end
        for (int i = 1; i < acc.size(); i++) begin
            n_checks++; if (acc[i] - acc[i-1] !== 10) begin
                n_errors++; $display("FAIL b2b_spacing%0d got=%0d want=10", i, acc[i] - acc[i-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
